keypad_scan_controller: RTL and testbench

//  Sequencer for the 4x4 matrix keypad: drives the column lines, samples the
//  row lines, debounces, and delivers one 4-bit digit with a single-cycle

---
 rtl/keypad_scan_controller_if.sv | 25 ++
 rtl/keypad_scan_controller.sv | 181 ++++++++++++++++++
 tb/tb_keypad_scan_controller.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_controller_if.sv
// Keypad pin and digit-output bundle between the scan controller (master) and the pads/consumer (slave).
// Pure wiring: no latency and no backpressure; the digit side is a fire-and-forget one-cycle strobe.
interface keypad_scan_controller_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] digit;
    logic       digit_dv;
    logic       key_held;

    modport master (
        input  row,
        output col,
        output digit,
        output digit_dv,
        output key_held
    );

    modport slave (
        output row,
        input  col,
        input  digit,
        input  digit_dv,
        input  key_held
    );
endinterface

// File: rtl/keypad_scan_controller.sv
// 4x4 keypad scanner: column drive, 2-flop row sync, per-frame debounce FSM, one DV pulse per accepted press.
// Latency DEBOUNCE_SCANS frames + 1 clk from a steady press; no backpressure, DV is a one-cycle strobe.
module keypad_scan_controller #(
    parameter int CLKS_PER_COL   = 8,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset,
    keypad_scan_controller_if.master kp
);

    localparam int CNT_W = (CLKS_PER_COL > 1) ? $clog2(CLKS_PER_COL) : 1;
    localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(CLKS_PER_COL - 1);
    localparam logic [DB_W-1:0]  DB_DONE     = DB_W'(DEBOUNCE_SCANS);

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_PRESS_PEND = 2'd1;
    localparam logic [1:0] ST_HELD       = 2'd2;
    localparam logic [1:0] ST_REL_PEND   = 2'd3;

    logic [3:0]       row_meta;
    logic [3:0]       row_sync;
    logic [1:0]       col_idx;
    logic [CNT_W-1:0] settle;
    logic [3:0][3:0]  col_rows;
    logic [1:0]       state;
    logic [DB_W-1:0]  cnt;
    logic [DB_W-1:0]  cnt_inc;
    logic [3:0]       cand;
    logic [3:0]       digit_q;
    logic             dv_q;
    logic             held_q;

    logic             sample_edge;
    logic             frame_edge;
    logic [15:0]      low_bits;
    logic [1:0]       n_low;
    logic [3:0]       hit_key;
    logic             frame_empty;
    logic             frame_single;

    // Bit index is row*4 + col.
    function automatic logic [3:0] key_map(input logic [3:0] idx);
        case (idx)
            4'd0:    key_map = 4'h1;
            4'd1:    key_map = 4'h2;
            4'd2:    key_map = 4'h3;
            4'd3:    key_map = 4'hA;
            4'd4:    key_map = 4'h4;
            4'd5:    key_map = 4'h5;
            4'd6:    key_map = 4'h6;
            4'd7:    key_map = 4'hB;
            4'd8:    key_map = 4'h7;
            4'd9:    key_map = 4'h8;
            4'd10:   key_map = 4'h9;
            4'd11:   key_map = 4'hC;
            4'd12:   key_map = 4'hE;
            4'd13:   key_map = 4'h0;
            4'd14:   key_map = 4'hF;
            default: key_map = 4'hD;
        endcase
    endfunction

    assign sample_edge = (settle == SETTLE_LAST);
    assign frame_edge  = sample_edge && (col_idx == 2'd3);
    assign cnt_inc     = cnt + DB_W'(1);

    // Column 3 is judged straight from the synchronizer since it is being stored on this same edge.
    always_comb begin
        low_bits = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                low_bits[r*4 + c] = (c == 3) ? ~row_sync[r] : ~col_rows[c][r];
            end
        end
    end

    always_comb begin
        n_low   = 2'd0;
        hit_key = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (low_bits[i]) begin
                if (n_low != 2'd2) n_low = n_low + 2'd1;
                hit_key = key_map(4'(i));
            end
        end
    end

    assign frame_empty  = (n_low == 2'd0);
    assign frame_single = (n_low == 2'd1);

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
            col_idx  <= 2'd0;
            settle   <= '0;
            col_rows <= '1;
            state    <= ST_IDLE;
            cnt      <= '0;
            cand     <= 4'h0;
            digit_q  <= 4'h0;
            dv_q     <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            row_meta <= kp.row;
            row_sync <= row_meta;
            dv_q     <= 1'b0;

            if (sample_edge) begin
                col_rows[col_idx] <= row_sync;
                col_idx           <= col_idx + 2'd1;
                settle            <= '0;
            end else begin
                settle <= settle + CNT_W'(1);
            end

            if (frame_edge) begin
                case (state)
                    ST_IDLE: begin
                        if (frame_single) begin
                            state <= ST_PRESS_PEND;
                            cand  <= hit_key;
                            cnt   <= DB_W'(1);
                        end
                    end
                    ST_PRESS_PEND: begin
                        if (frame_single && (hit_key == cand)) begin
                            if (cnt_inc == DB_DONE) begin
                                state   <= ST_HELD;
                                cnt     <= '0;
                                digit_q <= cand;
                                dv_q    <= 1'b1;
                                held_q  <= 1'b1;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else if (frame_single) begin
                            cand <= hit_key;
                            cnt  <= DB_W'(1);
                        end else begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end
                    end
                    ST_HELD: begin
                        if (frame_empty) begin
                            state <= ST_REL_PEND;
                            cnt   <= DB_W'(1);
                        end
                    end
                    ST_REL_PEND: begin
                        if (frame_empty) begin
                            if (cnt_inc == DB_DONE) begin
                                state  <= ST_IDLE;
                                cnt    <= '0;
                                held_q <= 1'b0;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            state <= ST_HELD;
                            cnt   <= '0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign kp.col      = ~(4'b0001 << col_idx);
    assign kp.digit    = digit_q;
    assign kp.digit_dv = dv_q;
    assign kp.key_held = held_q;

endmodule

// File: tb/tb_keypad_scan_controller.sv
// Bench for keypad_scan_controller: keypad matrix model, frame-aligned vector table, DV scoreboard.
module tb_keypad_scan_controller;

    localparam int FRAME = 32;

    typedef struct {
        string       name;
        logic [15:0] keys;
        int          frames;
        int          dv;
        logic [3:0]  digit;
        logic        held;
    } vec_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] keys  = '0;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          dv_seen  = 0;
    logic [3:0]  exp_q[$];
    vec_t        tbl[$];

    keypad_scan_controller_if kif();

    keypad_scan_controller #(
        .CLKS_PER_COL   (8),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .i_Clk   (clk),
        .i_Reset (reset),
        .kp      (kif.master)
    );

    always #5 clk = ~clk;

    // Pressed key at bit row*4+col pulls its row low while its column is driven low.
    always_comb begin
        kif.row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!kif.col[c] && keys[r*4 + c]) kif.row[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input string n, input logic [15:0] k, input int f,
                       input int dv, input logic [3:0] d, input logic h);
        vec_t v;
        v.name   = n;
        v.keys   = k;
        v.frames = f;
        v.dv     = dv;
        v.digit  = d;
        v.held   = h;
        tbl.push_back(v);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_col"},   32'(kif.col),      32'h0000000E);
        check({tag, "_dv"},    32'(kif.digit_dv), 32'd0);
        check({tag, "_digit"}, 32'(kif.digit),    32'd0);
        check({tag, "_held"},  32'(kif.key_held), 32'd0);
    endtask

    initial begin
        logic [3:0] col_exp;

        fork
            begin : monitor
                logic       prev_dv;
                logic [3:0] last_d;
                logic [3:0] e;
                prev_dv = 1'b0;
                last_d  = 4'h0;
                forever begin
                    @(posedge clk);
                    #1;
                    if (kif.digit_dv === 1'b1) begin
                        dv_seen++;
                        check("dv_single_cycle", 32'(prev_dv), 32'd0);
                        check("dv_expected", 32'(exp_q.size() != 0), 32'd1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            check("dv_digit", 32'(kif.digit), 32'(e));
                        end
                    end else if (!reset) begin
                        check("digit_stable", 32'(kif.digit), 32'(last_d));
                    end
                    last_d  = kif.digit;
                    prev_dv = kif.digit_dv;
                end
            end
        join_none

        // Keys: 1=b0 2=b1 3=b2 5=b5 7=b8 9=b10 0=b13 #=b14
        add("press5",        16'h0020, 3, 1, 4'h5, 1'b1);
        add("hold5",         16'h0020, 10, 0, 4'h5, 1'b1);
        add("rel2",          16'h0000, 2, 0, 4'h5, 1'b1);
        add("bounce5",       16'h0020, 1, 0, 4'h5, 1'b1);
        add("rel3",          16'h0000, 3, 0, 4'h5, 1'b0);
        add("pressF",        16'h4000, 3, 1, 4'hF, 1'b1);
        add("relF",          16'h0000, 3, 0, 4'hF, 1'b0);
        for (int i = 0; i < 8; i++)
            add((i % 2 == 0) ? "alt9_on" : "alt9_off",
                (i % 2 == 0) ? 16'h0400 : 16'h0000, 1, 0, 4'hF, 1'b0);
        add("multi12",       16'h0003, 6, 0, 4'hF, 1'b0);
        add("multi_rel",     16'h0000, 1, 0, 4'hF, 1'b0);
        add("cand1",         16'h0001, 1, 0, 4'hF, 1'b0);
        add("cand_switch3",  16'h0004, 3, 1, 4'h3, 1'b1);
        add("rel3b",         16'h0000, 3, 0, 4'h3, 1'b0);
        add("short7",        16'h0100, 2, 0, 4'h3, 1'b0);
        add("short7_rel",    16'h0000, 1, 0, 4'h3, 1'b0);

        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_state("reset");

        for (int k = 1; k <= 4; k++) begin
            repeat (8) @(negedge clk);
            col_exp = ~(4'b0001 << (k % 4));
            check($sformatf("col_walk%0d", k), 32'(kif.col), 32'(col_exp));
        end
        check("idle_held", 32'(kif.key_held), 32'd0);

        foreach (tbl[i]) begin
            keys    = tbl[i].keys;
            dv_seen = 0;
            if (tbl[i].dv != 0) exp_q.push_back(tbl[i].digit);
            repeat (FRAME * tbl[i].frames) @(negedge clk);
            check({tbl[i].name, "_dv_count"}, 32'(dv_seen), 32'(tbl[i].dv));
            check({tbl[i].name, "_held"},     32'(kif.key_held), 32'(tbl[i].held));
            check({tbl[i].name, "_digit"},    32'(kif.digit), 32'(tbl[i].digit));
            check({tbl[i].name, "_pending"},  32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end

        // Reset in the middle of debouncing key 0 must discard the progress.
        keys    = 16'h2000;
        dv_seen = 0;
        repeat (2 * FRAME) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_state("midreset");
        repeat (2 * FRAME) @(negedge clk);
        check("midreset_no_early_dv", 32'(dv_seen), 32'd0);
        check("midreset_held_early",  32'(kif.key_held), 32'd0);
        exp_q.push_back(4'h0);
        repeat (FRAME) @(negedge clk);
        check("midreset_dv_count", 32'(dv_seen), 32'd1);
        check("midreset_held",     32'(kif.key_held), 32'd1);
        check("midreset_digit",    32'(kif.digit), 32'd0);
        check("midreset_pending",  32'(exp_q.size()), 32'd0);

        keys = 16'h0000;
        repeat (4) @(negedge clk);
        disable monitor;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
